sbox_subbytes_seq: RTL and testbench

//  Sequential SubBytes/InvSubBytes engine. Acts as the requester side of the byte-wide S-box lookup interface.

---
 rtl/sbox_subbytes_seq.sv | 165 ++++++++++++++++
 tb/tb_sbox_subbytes_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_subbytes_seq.sv
// Purpose : sequential SubBytes/InvSubBytes engine; streams the 16 bytes of one AES state
//           through a single shared external S-box and reassembles the substituted state.
// Latency : out_valid 17+SBOX_LAT cycles after input acceptance; one block per 18+SBOX_LAT cycles.
// Backpressure: in_ready only in IDLE (blocks never overlap); result held stable in DONE until out_ready.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_valid/in_ready            input handshake; in_block (byte 0 in MSBs), in_encrypt (1 = forward)
//   out_valid/out_ready          output handshake; out_block in the same byte order
//   sbox_byte_out, sbox_encrypt  request to the shared S-box (byte is 0 outside ISSUE)
//   sbox_byte_in                 S-box result, sampled SBOX_LAT cycles after its request
//   busy                         engine not in IDLE
//   abort                        only with SUBBYTES_ABORT_EN defined: drop the current block
// Build option: SUBBYTES_ABORT_EN adds the abort input.
module sbox_subbytes_seq #(
    parameter int SBOX_LAT = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_encrypt,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic [7:0]   sbox_byte_out,
    output logic         sbox_encrypt,
    input  logic [7:0]   sbox_byte_in,
`ifdef SUBBYTES_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   block_q;
    logic           enc_q;
    logic [127:0]   result_q, result_d;
    logic [4:0]     issue_idx_q, issue_idx_d;
    logic [4:0]     cap_idx_q, cap_idx_d;
    logic           accept;
    logic           issuing;
    logic           cap_fire;
    logic           abort_act;

`ifdef SUBBYTES_ABORT_EN
    assign abort_act = abort & (state_q != S_IDLE);
`else
    assign abort_act = 1'b0;
`endif

    assign in_ready     = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign out_block    = result_q;
    assign sbox_encrypt = enc_q;
    assign accept       = in_valid & in_ready;
    assign issuing      = (state_q == S_ISSUE);

    // Byte k lives at bit offset 8*(15-k); for a 4-bit k, 15-k is simply ~k.
    assign sbox_byte_out = issuing ? block_q[{~issue_idx_q[3:0], 3'b000} +: 8] : 8'h00;

    // Return tracking: a combinational S-box answers in the issue cycle; a pipelined
    // one answers when the tag launched with the request reaches the end of the chain.
    if (SBOX_LAT == 0) begin : g_comb
        assign cap_fire = issuing;
    end else begin : g_pipe
        logic [SBOX_LAT-1:0] tag_q, tag_d;

        always_comb begin
            tag_d    = '0;
            tag_d[0] = issuing;
            for (int i = 1; i < SBOX_LAT; i++) begin
                tag_d[i] = tag_q[i-1];
            end
            // Requests still in the S-box pipeline are forgotten on abort.
            if (abort_act) begin
                tag_d = '0;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                tag_q <= '0;
            end else begin
                tag_q <= tag_d;
            end
        end

        assign cap_fire = tag_q[SBOX_LAT-1];
    end

    always_comb begin
        state_d     = state_q;
        issue_idx_d = issue_idx_q;
        cap_idx_d   = cap_idx_q;
        result_d    = result_q;

        if (cap_fire) begin
            result_d[{~cap_idx_q[3:0], 3'b000} +: 8] = sbox_byte_in;
            cap_idx_d = cap_idx_q + 5'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d     = S_ISSUE;
                    issue_idx_d = 5'd0;
                    cap_idx_d   = 5'd0;
                end
            end
            S_ISSUE: begin
                issue_idx_d = issue_idx_q + 5'd1;
                if (issue_idx_d == 5'd16) begin
                    state_d = (SBOX_LAT == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave on the cycle the last byte is captured so DONE starts right after it.
                if (cap_idx_d == 5'd16) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_act) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            block_q     <= '0;
            enc_q       <= 1'b1;
            result_q    <= '0;
            issue_idx_q <= '0;
            cap_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            issue_idx_q <= issue_idx_d;
            cap_idx_q   <= cap_idx_d;
            if (accept) begin
                block_q <= in_block;
                enc_q   <= in_encrypt;
            end
        end
    end

endmodule

// File: tb/tb_sbox_subbytes_seq.sv
// Purpose : checks sbox_subbytes_seq with a combinational (LAT 0) and a pipelined (LAT 2) S-box.
// Latency : both engines receive identical stimulus; each result is compared with a GF(2^8) reference.
// Backpressure: out_ready is held high, or low for several DONE cycles in the stall scenario.
module tb_sbox_subbytes_seq;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_encrypt;
    logic [127:0] in_block;
    logic         out_ready;

    logic         in_ready0, out_valid0, enc0, busy0;
    logic [127:0] ob0;
    logic [7:0]   so0, si0;
    logic         in_ready2, out_valid2, enc2, busy2;
    logic [127:0] ob2;
    logic [7:0]   so2, si2;
    logic [7:0]   p1, p2;
`ifdef SUBBYTES_ABORT_EN
    logic         abort;
`endif

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sbox_subbytes_seq #(.SBOX_LAT(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready0), .in_encrypt(in_encrypt), .in_block(in_block),
        .out_valid(out_valid0), .out_ready(out_ready), .out_block(ob0),
        .sbox_byte_out(so0), .sbox_encrypt(enc0), .sbox_byte_in(si0),
`ifdef SUBBYTES_ABORT_EN
        .abort(abort),
`endif
        .busy(busy0)
    );

    sbox_subbytes_seq #(.SBOX_LAT(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready2), .in_encrypt(in_encrypt), .in_block(in_block),
        .out_valid(out_valid2), .out_ready(out_ready), .out_block(ob2),
        .sbox_byte_out(so2), .sbox_encrypt(enc2), .sbox_byte_in(si2),
`ifdef SUBBYTES_ABORT_EN
        .abort(abort),
`endif
        .busy(busy2)
    );

    // External S-boxes: one combinational, one with two register stages.
    assign si0 = enc0 ? sb[so0] : isb[so0];
    always @(posedge clk) begin
        p1 <= enc2 ? sb[so2] : isb[so2];
        p2 <= p1;
    end
    assign si2 = p2;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        logic       hi;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // AES S-box from first principles: multiplicative inverse then affine map.
    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] sub_ref(input logic [127:0] blk, input logic enc);
        logic [127:0] r;
        logic [7:0]   b;
        for (int k = 0; k < 16; k++) begin
            b = blk[8*(15-k) +: 8];
            r[8*(15-k) +: 8] = enc ? sb[b] : isb[b];
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (in_ready0 && in_ready2) break;
            @(negedge clk);
        end
        chk("idle_wait", {126'd0, in_ready0, in_ready2}, 128'd3);
    endtask

    // Push one block through both engines; hold>0 keeps out_ready low that many DONE cycles.
    task automatic run_block(input logic [127:0] blk, input logic enc, input int hold,
                             output logic [127:0] res);
        logic [127:0] exp, seq0, seq2, ob0_s, ob2_s;
        int lat0, lat2, rdy0, enc_bad, zero_bad;
        exp      = sub_ref(blk, enc);
        lat0     = -1;
        lat2     = -1;
        rdy0     = -1;
        enc_bad  = 0;
        zero_bad = 0;
        seq0     = 'x;
        seq2     = 'x;
        ob0_s    = 'x;
        ob2_s    = 'x;
        wait_idle();
        in_valid   = 1'b1;
        in_block   = blk;
        in_encrypt = enc;
        out_ready  = (hold == 0);
        @(negedge clk);
        in_valid   = 1'b0;
        in_encrypt = ~enc;
        in_block   = rnd128();
        for (int c = 1; c <= 40; c++) begin
            if (c <= 16) begin
                seq0[8*(16-c) +: 8] = so0;
                seq2[8*(16-c) +: 8] = so2;
                if (enc0 !== enc || enc2 !== enc) enc_bad++;
            end else if (so0 !== 8'h00 || so2 !== 8'h00) begin
                zero_bad++;
            end
            if (out_valid0 && lat0 < 0) begin lat0 = c; ob0_s = ob0; end
            if (out_valid2 && lat2 < 0) begin lat2 = c; ob2_s = ob2; end
            if (lat0 >= 0 && rdy0 < 0 && c > lat0 && in_ready0) rdy0 = c;
            if (lat2 >= 0 && (hold > 0 || rdy0 >= 0)) break;
            @(negedge clk);
        end
        chk("issue_order0", seq0, blk);
        chk("issue_order2", seq2, blk);
        chk("dir_latched", 128'(enc_bad), 128'd0);
        chk("idle_byte_zero", 128'(zero_bad), 128'd0);
        chk("latency0", 128'(lat0), 128'd17);
        chk("latency2", 128'(lat2), 128'd19);
        chk("result0", ob0_s, exp);
        chk("result2", ob2_s, exp);
        if (hold == 0) begin
            chk("in_ready_back0", 128'(rdy0), 128'd18);
        end else begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (h == 1) begin in_valid = 1'b1; in_block = rnd128(); end
                if (h == 2) in_valid = 1'b0;
                chk("stall_flags", {124'd0, out_valid0, out_valid2, in_ready0, in_ready2}, 128'hC);
                chk("stall_blk0", ob0, ob0_s);
                chk("stall_blk2", ob2, ob2_s);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            chk("release_flags", {124'd0, out_valid0, out_valid2, in_ready0, in_ready2}, 128'h3);
        end
        res = ob0_s;
    endtask

    // Start a block and return in its ISSUE cycle carrying issue_idx 7.
    task automatic start_to_idx7(input logic [127:0] blk);
        wait_idle();
        in_valid   = 1'b1;
        in_block   = blk;
        in_encrypt = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("byte7_issued", {120'd0, so0}, {120'd0, blk[8*8 +: 8]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [127:0] r, r2, blk, kat;
        logic         e;
        int           seen;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_encrypt = 1'b0;
        in_block   = '0;
        out_ready  = 1'b1;
`ifdef SUBBYTES_ABORT_EN
        abort      = 1'b0;
`endif
        build_tables();
        repeat (2) @(negedge clk);
        chk("reset_flags", {120'd0, in_ready0, out_valid0, enc0, busy0, in_ready2, out_valid2, enc2, busy2},
            128'hAA);
        chk("reset_blk0", ob0, 128'd0);
        chk("reset_blk2", ob2, 128'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_block(128'd0, 1'b1, 0, r);
        chk("zero_all_63", r, {16{8'h63}});

        kat = 128'h00112233445566778899AABBCCDDEEFF;
        run_block(kat, 1'b1, 0, r);
        chk("kat_enc", r, 128'h638293C31BFC33F5C4EEACEA4BC12816);
        run_block(r, 1'b0, 0, r2);
        chk("kat_dec", r2, kat);

        run_block(rnd128(), 1'($urandom), 5, r);

        // Asynchronous reset in the middle of ISSUE.
        start_to_idx7(rnd128());
        reset_n = 1'b0;
        #1;
        chk("midrst_flags", {120'd0, in_ready0, out_valid0, enc0, busy0, in_ready2, out_valid2, enc2, busy2},
            128'hAA);
        chk("midrst_bytes", {112'd0, so0, so2}, 128'd0);
        chk("midrst_blk", {ob0, ob2} == 256'd0 ? 128'd1 : 128'd0, 128'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_block(128'd0, 1'b1, 0, r);
        chk("post_rst_63", r, {16{8'h63}});

`ifdef SUBBYTES_ABORT_EN
        start_to_idx7(rnd128());
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {124'd0, busy0, busy2, in_ready0, in_ready2}, 128'h3);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid0 || out_valid2) seen++;
            @(negedge clk);
        end
        chk("abort_no_valid", 128'(seen), 128'd0);
        blk = rnd128();
        run_block(blk, 1'b1, 0, r);
`else
        seen = 0;
`endif

        for (int n = 0; n < 12; n++) begin
            blk = rnd128();
            e   = 1'($urandom);
            run_block(blk, e, (n % 4 == 3) ? 2 : 0, r);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
